mdio_phy_responder: RTL and testbench
=====================================

MDIO_PHY_RESPONDER -- requirements
Module: mdio_phy_responder

Interface
REQ-001 Parameters (name, default, meaning): PHY_ID1, 16'h0022, reset value of register 2; PHY_ID2, 16'h1622, reset value of register 3; PRE_LEN, 32, minimum consecutive preamble ones before a frame is accepted.
REQ-002 Ports (name direction width meaning): sys_clk in 1 system clock; sys_rst_n in 1 reset.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 mdc in 1 MDIO clock from the station manager, asynchronous to sys_clk.
REQ-005 mdio_i in 1 sampled MDIO line; mdio_o out 1 drive value; mdio_oe out 1 drive enable (tri-state built at top level).
REQ-006 phy_addr in 5 this responder's PHY address, quasi-static.
REQ-007 cfg_we in 1, cfg_addr in 5, cfg_wdata in 16: host preload write port.
REQ-008 cfg_rdata out 16: register[cfg_addr], registered, 1-cycle latency.
REQ-009 frame_rd out 1, frame_wr out 1: single-cycle pulses on completed matching read/write frame; frame_reg out 5: REGAD of last matching frame.

Function
REQ-010 mdc and mdio_i pass through 2-FF synchronizers; MDC rise/fall are detected as single-cycle strobes on synchronized mdc; mdio sampled only on rise strobe.
REQ-011 MDC period SHALL be >= 8 sys_clk cycles; shorter periods are unsupported.
REQ-012 States: IDLE, START, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP.
REQ-013 IDLE: counts consecutive sampled ones (saturating at PRE_LEN); a 0 with count >= PRE_LEN -> START; a 0 with count < PRE_LEN clears count, stays IDLE.
REQ-014 START: next bit must be 1 (ST=01) else IDLE with count cleared.
REQ-015 OP: 2 bits; 10 = read, 01 = write; 00/11 -> IDLE, count cleared.
REQ-016 PHYAD, REGAD: 5 bits each, MSB first; PHYAD != phy_addr -> SKIP after REGAD.
REQ-017 SKIP: ignores remaining 18 rise strobes (TA + data), never drives, then IDLE.
REQ-018 Read, address match: register[REGAD] latched into shift register on the rise strobe sampling last REGAD bit; first TA bit period undriven.
REQ-019 Read: on fall strobe following first TA rise, mdio_oe=1, mdio_o=0; on each following fall strobe shift out D15..D0; on fall strobe after D0 rise, mdio_oe=0, frame_rd pulses, state IDLE.
REQ-020 Write: TA 2 bits ignored (not checked); 16 data bits shifted MSB first; on rise sampling D0, register written, frame_wr pulses, IDLE.
REQ-021 Preamble count restarts from 0 after every frame (no preamble suppression).
REQ-022 Host cfg_we and MDIO write commit same cycle, same address: cfg_wdata wins; different addresses: both commit.
REQ-023 cfg_we during an active read to same register does not alter already-latched read data.
REQ-024 mdio_oe SHALL be 0 in every state except TA(second bit)/RDATA of a matching read.

Reset
REQ-025 Async assert: state IDLE, preamble count 0, mdio_oe=0, mdio_o=1, frame_rd=frame_wr=0, frame_reg=0, cfg_rdata=0, shift regs 0.
REQ-026 Registers reset to 0 except reg 2 = PHY_ID1, reg 3 = PHY_ID2.
REQ-027 Reset mid-frame releases mdio within one sys_clk of assertion; post-reset, a full preamble is required.

Structure
REQ-028 Package mdio_pkg: state enum, ST/OP_RD/OP_WR constants, frame field widths, PRE_LEN default.
REQ-029 Sub-module mdio_edge_sync: 2-FF synchronizer plus rise/fall strobe generation, instantiated for mdc and mdio_i.
REQ-030 Register file 32x16 flops, single write port arbitrated per REQ-022.

Verification
REQ-031 Bench: sys_clk 50 MHz, MDC 1 MHz, pullup on mdio, phy_addr=5'h04.
REQ-032 Read reg 2 at PHYAD 04 after reset -> master samples TA2=0, data 16'h0022, frame_rd pulse, frame_reg=2.
REQ-033 cfg preload reg 10=16'h55AA, MDIO write reg 11=16'h1234, read both -> 16'h55AA, 16'h1234; cfg_rdata of 11 = 16'h1234.
REQ-034 Read at PHYAD 05 -> mdio_oe never asserted, no pulses, next frame to 04 succeeds.
REQ-035 Preamble of 31 ones then frame -> ignored; OP=11 frame -> ignored, IDLE.
REQ-036 sys_rst_n low mid-RDATA -> mdio_oe=0 within one cycle; register contents return to reset values.
REQ-037 Same-cycle cfg_we and MDIO write to reg 12 (cfg 16'hBEEF, MDIO 16'h0001) -> reg 12 = 16'hBEEF.

Source files
------------

// File: rtl/mdio_pkg.sv
// Shared types and constants for the MDIO PHY responder: frame field widths,
// opcodes and the frame-decoder state encoding.
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_OP,
    S_PHYAD,
    S_REGAD,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } mdio_state_t;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;

  localparam int PHYAD_W     = 5;
  localparam int REGAD_W     = 5;
  localparam int DATA_W      = 16;
  localparam int TA_W        = 2;
  localparam int SKIP_BITS   = TA_W + DATA_W;
  localparam int NUM_REGS    = 1 << REGAD_W;
  localparam int PRE_LEN_DEF = 32;

endpackage

// File: rtl/mdio_edge_sync.sv
// Two-flop synchronizer for an asynchronous input, plus single-cycle
// rise and fall strobes derived from the synchronized level.
module mdio_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO slave: decodes frames from the station manager on strobes
// of a synchronized MDC and serves a 32x16 register file, also host-writable.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter logic [DATA_W-1:0] PHY_ID1 = 16'h0022,
  parameter logic [DATA_W-1:0] PHY_ID2 = 16'h1622,
  parameter int                PRE_LEN = PRE_LEN_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               mdc,
  input  logic               mdio_i,
  output logic               mdio_o,
  output logic               mdio_oe,
  input  logic [PHYAD_W-1:0] phy_addr,
  input  logic               cfg_we,
  input  logic [REGAD_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  cfg_rdata,
  output logic               frame_rd,
  output logic               frame_wr,
  output logic [REGAD_W-1:0] frame_reg
);

  localparam int             PRE_W      = $clog2(PRE_LEN + 1);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRE_LEN);
  localparam logic [4:0]     ADDR_LAST  = 5'(PHYAD_W - 1);
  localparam logic [4:0]     TA_LAST    = 5'(TA_W - 1);
  localparam logic [4:0]     DATA_LAST  = 5'(DATA_W - 1);
  localparam logic [4:0]     RD_RELEASE = 5'(DATA_W);
  localparam logic [4:0]     SKIP_LAST  = 5'(SKIP_BITS - 1);

  logic w_mdcSync, w_mdcRise, w_mdcFall;
  logic w_mdioBit, w_mdioRise, w_mdioFall;
  logic w_unused;

  mdio_edge_sync #(.RST_VAL(1'b0)) u_mdcSync (
    .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_async(mdc),
    .o_sync(w_mdcSync), .o_rise(w_mdcRise), .o_fall(w_mdcFall)
  );

  // MDIO idles high through the board pull-up, so its synchronizer resets to 1.
  mdio_edge_sync #(.RST_VAL(1'b1)) u_mdioSync (
    .i_clk(sys_clk), .i_rst_n(sys_rst_n), .i_async(mdio_i),
    .o_sync(w_mdioBit), .o_rise(w_mdioRise), .o_fall(w_mdioFall)
  );

  assign w_unused = &{1'b0, w_mdcSync, w_mdioRise, w_mdioFall};

  mdio_state_t          r_state, w_stateNxt;
  logic [4:0]           r_cnt, w_cntNxt;
  logic [PRE_W-1:0]     r_pre, w_preNxt;
  logic [1:0]           r_op, w_opNxt;
  logic [PHYAD_W-1:0]   r_phyad, w_phyadNxt;
  logic [REGAD_W-1:0]   r_regad, w_regadNxt;
  logic [DATA_W-1:0]    r_shift, w_shiftNxt;
  logic                 r_oe, w_oeNxt;
  logic                 r_o, w_oNxt;
  logic                 r_frameRd, w_frameRdNxt;
  logic                 r_frameWr, w_frameWrNxt;
  logic [REGAD_W-1:0]   r_frameReg, w_frameRegNxt;
  logic                 w_regWe;
  logic [DATA_W-1:0]    r_regs [NUM_REGS];
  logic [DATA_W-1:0]    r_cfgRdata;

  always_comb begin
    w_stateNxt    = r_state;
    w_cntNxt      = r_cnt;
    w_preNxt      = r_pre;
    w_opNxt       = r_op;
    w_phyadNxt    = r_phyad;
    w_regadNxt    = r_regad;
    w_shiftNxt    = r_shift;
    w_oeNxt       = r_oe;
    w_oNxt        = r_o;
    w_frameRdNxt  = 1'b0;
    w_frameWrNxt  = 1'b0;
    w_frameRegNxt = r_frameReg;
    w_regWe       = 1'b0;
    case (r_state)
      S_IDLE: if (w_mdcRise) begin
        if (w_mdioBit) begin
          if (r_pre < PRE_MAX) w_preNxt = r_pre + 1'b1;
        end else begin
          w_preNxt = '0;
          if (r_pre >= PRE_MAX) w_stateNxt = S_START;
        end
      end
      S_START: if (w_mdcRise) begin
        w_cntNxt   = '0;
        w_stateNxt = (w_mdioBit == ST[0]) ? S_OP : S_IDLE;
      end
      S_OP: if (w_mdcRise) begin
        w_opNxt  = {r_op[0], w_mdioBit};
        w_cntNxt = r_cnt + 5'd1;
        if (r_cnt != 5'd0) begin
          w_cntNxt   = '0;
          w_stateNxt = (w_opNxt == OP_RD || w_opNxt == OP_WR) ? S_PHYAD : S_IDLE;
        end
      end
      S_PHYAD: if (w_mdcRise) begin
        w_phyadNxt = {r_phyad[PHYAD_W-2:0], w_mdioBit};
        w_cntNxt   = r_cnt + 5'd1;
        if (r_cnt == ADDR_LAST) begin
          w_cntNxt   = '0;
          w_stateNxt = S_REGAD;
        end
      end
      // The read word is captured as the last address bit arrives, so later
      // host writes to that register cannot disturb a read in flight.
      S_REGAD: if (w_mdcRise) begin
        w_regadNxt = {r_regad[REGAD_W-2:0], w_mdioBit};
        w_cntNxt   = r_cnt + 5'd1;
        if (r_cnt == ADDR_LAST) begin
          w_cntNxt = '0;
          if (r_phyad != phy_addr) begin
            w_stateNxt = S_SKIP;
          end else begin
            w_stateNxt = S_TA;
            if (r_op == OP_RD) w_shiftNxt = r_regs[w_regadNxt];
          end
        end
      end
      S_TA: begin
        if (r_op == OP_RD) begin
          if (w_mdcRise) begin
            w_cntNxt = TA_LAST;
          end else if (w_mdcFall && r_cnt == TA_LAST) begin
            w_oeNxt    = 1'b1;
            w_oNxt     = 1'b0;
            w_cntNxt   = '0;
            w_stateNxt = S_RDATA;
          end
        end else if (w_mdcRise) begin
          w_cntNxt = r_cnt + 5'd1;
          if (r_cnt == TA_LAST) begin
            w_cntNxt   = '0;
            w_stateNxt = S_WDATA;
          end
        end
      end
      S_RDATA: if (w_mdcFall) begin
        if (r_cnt == RD_RELEASE) begin
          w_oeNxt       = 1'b0;
          w_oNxt        = 1'b1;
          w_frameRdNxt  = 1'b1;
          w_frameRegNxt = r_regad;
          w_cntNxt      = '0;
          w_stateNxt    = S_IDLE;
        end else begin
          w_oNxt     = r_shift[DATA_W-1];
          w_shiftNxt = {r_shift[DATA_W-2:0], 1'b0};
          w_cntNxt   = r_cnt + 5'd1;
        end
      end
      S_WDATA: if (w_mdcRise) begin
        w_shiftNxt = {r_shift[DATA_W-2:0], w_mdioBit};
        w_cntNxt   = r_cnt + 5'd1;
        if (r_cnt == DATA_LAST) begin
          w_regWe       = 1'b1;
          w_frameWrNxt  = 1'b1;
          w_frameRegNxt = r_regad;
          w_cntNxt      = '0;
          w_stateNxt    = S_IDLE;
        end
      end
      S_SKIP: if (w_mdcRise) begin
        w_cntNxt = r_cnt + 5'd1;
        if (r_cnt == SKIP_LAST) begin
          w_cntNxt   = '0;
          w_stateNxt = S_IDLE;
        end
      end
      default: w_stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_pre      <= '0;
      r_op       <= '0;
      r_phyad    <= '0;
      r_regad    <= '0;
      r_shift    <= '0;
      r_oe       <= 1'b0;
      r_o        <= 1'b1;
      r_frameRd  <= 1'b0;
      r_frameWr  <= 1'b0;
      r_frameReg <= '0;
    end else begin
      r_state    <= w_stateNxt;
      r_cnt      <= w_cntNxt;
      r_pre      <= w_preNxt;
      r_op       <= w_opNxt;
      r_phyad    <= w_phyadNxt;
      r_regad    <= w_regadNxt;
      r_shift    <= w_shiftNxt;
      r_oe       <= w_oeNxt;
      r_o        <= w_oNxt;
      r_frameRd  <= w_frameRdNxt;
      r_frameWr  <= w_frameWrNxt;
      r_frameReg <= w_frameRegNxt;
    end
  end

  // The host write is issued last so it overrides an MDIO write to the same address.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : '0;
      r_cfgRdata <= '0;
    end else begin
      if (w_regWe) r_regs[r_regad] <= w_shiftNxt;
      if (cfg_we)  r_regs[cfg_addr] <= cfg_wdata;
      r_cfgRdata <= r_regs[cfg_addr];
    end
  end

  assign mdio_o    = r_o;
  assign mdio_oe   = r_oe;
  assign cfg_rdata = r_cfgRdata;
  assign frame_rd  = r_frameRd;
  assign frame_wr  = r_frameWr;
  assign frame_reg = r_frameReg;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Station-manager model driving MDIO frames into mdio_phy_responder and
// comparing every observable against a register-array reference model.
module tb_mdio_phy_responder;

  localparam logic [4:0] MY_ADDR    = 5'h04;
  localparam int         PRE_FULL   = 32;
  localparam int         OE_CYCLES  = 17 * 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        mdc = 1'b0;
  logic        mdio_o, mdio_oe;
  logic        masterOe = 1'b0;
  logic        masterBit = 1'b1;
  logic        mdioLine;
  logic [4:0]  phy_addr = MY_ADDR;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = 5'd0;
  logic [15:0] cfg_wdata = 16'h0;
  logic [15:0] cfg_rdata;
  logic        frame_rd, frame_wr;
  logic [4:0]  frame_reg;

  int checkCount = 0;
  int errCount   = 0;
  int rdPulses   = 0;
  int wrPulses   = 0;
  int oeCycles   = 0;

  logic [15:0] model [32];
  logic [4:0]  lastReg;

  assign mdioLine = mdio_oe ? mdio_o : (masterOe ? masterBit : 1'b1);

  mdio_phy_responder dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mdc(mdc),
    .mdio_i(mdioLine), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .phy_addr(phy_addr), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
    .frame_rd(frame_rd), .frame_wr(frame_wr), .frame_reg(frame_reg)
  );

  always #10 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (frame_rd) rdPulses <= rdPulses + 1;
    if (frame_wr) wrPulses <= wrPulses + 1;
    if (mdio_oe)  oeCycles <= oeCycles + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 32; i++) model[i] = 16'h0;
    model[2] = 16'h0022;
    model[3] = 16'h1622;
    lastReg  = 5'd0;
  endtask

  task automatic mdcBit(input bit drive, input logic val, output logic smp);
    mdc = 1'b0;
    masterOe = drive;
    masterBit = val;
    #500;
    mdc = 1'b1;
    smp = mdioLine;
    #500;
  endtask

  task automatic applyStimulus(input int preLen, input logic [1:0] op,
                               input logic [4:0] phyad, input logic [4:0] regad,
                               input logic [15:0] wdata, input bit collide,
                               input logic [4:0] cAddr, input logic [15:0] cData,
                               input int rstBit, output logic ta1,
                               output logic ta2, output logic [15:0] rdata);
    logic smp;
    rdata = 16'h0;
    ta1 = 1'b1;
    ta2 = 1'b1;
    for (int i = 0; i < preLen; i++) mdcBit(1, 1'b1, smp);
    mdcBit(1, 1'b0, smp);
    mdcBit(1, 1'b1, smp);
    mdcBit(1, op[1], smp);
    mdcBit(1, op[0], smp);
    for (int i = 4; i >= 0; i--) mdcBit(1, phyad[i], smp);
    for (int i = 4; i >= 0; i--) mdcBit(1, regad[i], smp);
    if (op == 2'b01) begin
      mdcBit(1, 1'b1, smp);
      mdcBit(1, 1'b0, smp);
      for (int i = 15; i >= 0; i--) begin
        if (collide && i == 0) begin
          mdc = 1'b0;
          masterBit = wdata[0];
          #500;
          mdc = 1'b1;
          @(posedge sys_clk);
          @(posedge sys_clk);
          #1;
          cfg_we = 1'b1;
          cfg_addr = cAddr;
          cfg_wdata = cData;
          @(posedge sys_clk);
          #1;
          cfg_we = 1'b0;
          checkOutput("collide_align_frame_wr", frame_wr, 1'b1);
          #442;
        end else begin
          mdcBit(1, wdata[i], smp);
        end
      end
      masterOe = 1'b0;
    end else begin
      mdcBit(0, 1'b1, ta1);
      mdcBit(0, 1'b1, ta2);
      for (int i = 15; i >= 0; i--) begin
        if (rstBit == 15 - i) begin
          mdc = 1'b0;
          #200;
          checkOutput("oe_before_reset", mdio_oe, 1'b1);
          sys_rst_n = 1'b0;
          #5;
          checkOutput("oe_after_reset", mdio_oe, 1'b0);
          #295;
          mdc = 1'b1;
          rdata[i] = mdioLine;
          #500;
        end else begin
          mdcBit(0, 1'b1, smp);
          rdata[i] = smp;
        end
      end
    end
    mdc = 1'b0;
    #500;
  endtask

  task automatic runFrame(input int preLen, input logic [1:0] op,
                          input logic [4:0] phyad, input logic [4:0] regad,
                          input logic [15:0] wdata, input bit collide,
                          input logic [4:0] cAddr, input logic [15:0] cData);
    int rd0 = rdPulses;
    int wr0 = wrPulses;
    int oe0 = oeCycles;
    bit accepted = (preLen >= PRE_FULL) && (op == 2'b10 || op == 2'b01);
    bit match = accepted && (phyad == MY_ADDR);
    bit isRd = match && (op == 2'b10);
    bit isWr = match && (op == 2'b01);
    logic [15:0] expRd = model[regad];
    logic ta1, ta2;
    logic [15:0] rdata;
    applyStimulus(preLen, op, phyad, regad, wdata, collide, cAddr, cData,
                  -1, ta1, ta2, rdata);
    checkOutput("frame_rd_pulses", rdPulses - rd0, isRd);
    checkOutput("frame_wr_pulses", wrPulses - wr0, isWr);
    checkOutput("oe_cycles", oeCycles - oe0, isRd ? OE_CYCLES : 0);
    if (isRd) begin
      checkOutput("ta1_undriven", ta1, 1'b1);
      checkOutput("ta2_zero", ta2, 1'b0);
      checkOutput("read_data", rdata, expRd);
    end
    if (match) lastReg = regad;
    checkOutput("frame_reg", frame_reg, lastReg);
    if (isWr) model[regad] = wdata;
    if (collide) model[cAddr] = cData;
  endtask

  task automatic cfgWrite(input logic [4:0] addr, input logic [15:0] data);
    @(posedge sys_clk);
    #3;
    cfg_we = 1'b1;
    cfg_addr = addr;
    cfg_wdata = data;
    @(posedge sys_clk);
    #3;
    cfg_we = 1'b0;
    model[addr] = data;
  endtask

  task automatic cfgCheck(input string tag, input logic [4:0] addr);
    cfg_addr = addr;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3;
    checkOutput(tag, cfg_rdata, model[addr]);
  endtask

  initial begin
    logic [1:0]  rOp;
    logic [4:0]  rPhy, rReg, rCAddr;
    logic [15:0] rData, rCData;
    bit          rCollide;
    logic        ta1, ta2;
    logic [15:0] rdata;
    int          rd0, rstBit;

    resetModel();
    #1 sys_rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3;
    checkOutput("rst_mdio_oe", mdio_oe, 1'b0);
    checkOutput("rst_mdio_o", mdio_o, 1'b1);
    checkOutput("rst_frame_rd", frame_rd, 1'b0);
    checkOutput("rst_frame_wr", frame_wr, 1'b0);
    checkOutput("rst_frame_reg", frame_reg, 5'd0);
    checkOutput("rst_cfg_rdata", cfg_rdata, 16'h0);
    sys_rst_n = 1'b1;
    cfgCheck("cfg_reg2_id1", 5'd2);
    cfgCheck("cfg_reg3_id2", 5'd3);
    cfgCheck("cfg_reg0_zero", 5'd0);

    $display("[TB] read PHY ID after reset");
    runFrame(32, 2'b10, MY_ADDR, 5'd2, 16'h0, 0, 5'd0, 16'h0);

    $display("[TB] host preload and MDIO write");
    cfgWrite(5'd10, 16'h55AA);
    runFrame(32, 2'b01, MY_ADDR, 5'd11, 16'h1234, 0, 5'd0, 16'h0);
    runFrame(32, 2'b10, MY_ADDR, 5'd10, 16'h0, 0, 5'd0, 16'h0);
    runFrame(32, 2'b10, MY_ADDR, 5'd11, 16'h0, 0, 5'd0, 16'h0);
    cfgCheck("cfg_reg11_after_mdio_write", 5'd11);

    $display("[TB] foreign PHY address then own address");
    runFrame(32, 2'b10, 5'h05, 5'd2, 16'h0, 0, 5'd0, 16'h0);
    runFrame(32, 2'b10, MY_ADDR, 5'd3, 16'h0, 0, 5'd0, 16'h0);

    $display("[TB] short preamble and illegal opcode");
    runFrame(31, 2'b10, MY_ADDR, 5'd2, 16'h0, 0, 5'd0, 16'h0);
    runFrame(32, 2'b11, MY_ADDR, 5'd2, 16'h0, 0, 5'd0, 16'h0);

    $display("[TB] same-cycle host and MDIO write");
    runFrame(32, 2'b01, MY_ADDR, 5'd12, 16'h0001, 1, 5'd12, 16'hBEEF);
    cfgCheck("cfg_reg12_host_wins", 5'd12);

    $display("[TB] randomized frames");
    for (int n = 0; n < 4; n++) begin
      rOp = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
      rPhy = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(5, 31)) : MY_ADDR;
      rReg = 5'($urandom_range(0, 31));
      rData = 16'($urandom);
      rCollide = (rOp == 2'b01) && (rPhy == MY_ADDR) && ($urandom_range(0, 1) == 1);
      rCAddr = 5'($urandom_range(0, 31));
      rCData = 16'($urandom);
      if ($urandom_range(0, 1) == 1) cfgWrite(5'($urandom_range(0, 31)), 16'($urandom));
      runFrame(32, rOp, rPhy, rReg, rData, rCollide, rCAddr, rCData);
    end
    cfgCheck("cfg_random_a", 5'($urandom_range(0, 31)));
    cfgCheck("cfg_random_b", 5'($urandom_range(0, 31)));

    $display("[TB] reset during read data phase");
    rstBit = $urandom_range(2, 13);
    rd0 = rdPulses;
    applyStimulus(32, 2'b10, MY_ADDR, 5'd11, 16'h0, 0, 5'd0, 16'h0,
                  rstBit, ta1, ta2, rdata);
    sys_rst_n = 1'b1;
    resetModel();
    checkOutput("rst_mid_frame_no_pulse", rdPulses - rd0, 0);
    checkOutput("rst_mid_frame_reg", frame_reg, 5'd0);
    checkOutput("rst_mid_frame_mdio_o", mdio_o, 1'b1);
    cfgCheck("post_rst_reg11", 5'd11);
    cfgCheck("post_rst_reg12", 5'd12);
    cfgCheck("post_rst_reg2", 5'd2);
    runFrame(32, 2'b10, MY_ADDR, 5'd3, 16'h0, 0, 5'd0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
